ifetch_buf: RTL and testbench
=============================

Name: ifetch_buf

Overview:
- Instruction prefetch stage between instruction memory and execute.
- Generates sequential fetch addresses and runs a req/ack handshake to a variable-latency instruction memory.
- Buffers returned words with their PC in a small FIFO and presents them to execute with valid/ready.
- Execute issues a redirect on a taken branch or jump: the FIFO is flushed and any in-flight stale response is discarded.

Parameters:
- DEPTH, 4, FIFO entries (power of two, 2..16).
- AW, 8, instruction memory word-address width.
- RESET_PC, 32'h00000000, fetch PC after reset.

Ports:
- clk  input  1  clock, rising edge.
- rstd  input  1  reset, asynchronous, active-low.
- redirect  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch PC, word-indexed.
- imem_req  output  1  fetch request, registered.
- imem_addr  output  AW  word address, equal to fpc[AW-1:0], registered.
- imem_ack  input  1  memory accepts the request; imem_rdata valid this cycle.
- imem_rdata  input  32  instruction word.
- ins_valid  output  1  FIFO head valid.
- ins  output  32  head instruction.
- ins_pc  output  32  PC of head instruction.
- ins_ready  input  1  execute consumes head.

Behaviour:
- Reset (async, rstd=0):
  - fpc=RESET_PC, state=IDLE, count=0, pointers=0, all FIFO storage=0.
  - imem_req=0, imem_addr=RESET_PC[AW-1:0], ins_valid=0, ins=0, ins_pc=0.
  - Reset mid-request abandons the request; memory must tolerate an abandoned request.
- PC arithmetic:
  - fpc is a 32-bit word index, +1 per issued request, wraps 32'hFFFFFFFF->0.
  - imem_addr wraps 2^AW-1 -> 0.
- Memory handshake:
  - imem_req and imem_addr are held stable until a cycle with imem_ack=1.
  - Ack may arrive in the first cycle req is high (zero wait) or any later cycle.
  - imem_ack while imem_req=0 is ignored.
- States:
  - IDLE: no request outstanding. If count<DEPTH and no redirect: imem_req<=1, addr<=fpc, -> REQ.
  - REQ: one request outstanding.
    - On ack: push {fpc_issued, imem_rdata}; fpc<=fpc+1.
    - Then, if count_next<DEPTH (count_next = count+1-pop), issue the next request immediately and stay in REQ (back-to-back, 1 instr/cycle with zero-wait memory).
    - Otherwise drop imem_req and go to IDLE.
  - DISCARD: a stale request is outstanding. imem_req stays high with its old address. On ack the data is dropped and the state goes to IDLE.
- Slot reservation: issue only when count (after this cycle's push/pop) < DEPTH, so every accepted response has a free slot. Overflow is impossible.
- Output side:
  - ins_valid = (count!=0); ins and ins_pc show the head entry.
  - Pop when ins_valid & ins_ready; head advances next cycle.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - ins_ready while empty has no effect.
- Redirect (highest priority, takes effect at the clock edge):
  - FIFO flushed: count=0 and pointers reset. The same-cycle pop and push are both ignored.
  - fpc<=redirect_pc.
  - In IDLE or DISCARD with no ack: -> IDLE from IDLE; DISCARD stays DISCARD. No new request is issued this cycle.
  - In REQ without ack: -> DISCARD.
  - In REQ or DISCARD with ack in the same cycle: the response is dropped and the state goes to IDLE.
  - First fetch at redirect_pc is issued the cycle after the state reaches IDLE, so ins_valid stays low at least 2 cycles after the redirect edge.
- Startup latency, zero-wait memory: imem_req rises at the first edge after rstd deasserts; ins_valid rises one edge later.

Test Plan:
- Reset, zero-wait ack, ins_ready=1 tied high -> imem_addr 0,1,2,... one per cycle; ins/ins_pc stream pc 0,1,2 with matching words; ins_valid continuous from cycle 2.
- ins_ready=0, DEPTH=4 -> exactly 4 acks accepted, then imem_req=0. Raising ins_ready gives in-order pops of pc 0..3 and refetch resumes at pc 4.
- Memory with 3-cycle ack latency, redirect to 32'h40 while a request to pc 5 is outstanding -> state DISCARD, pc-5 data never appears. Next request addr=8'h40; first ins_pc=32'h40.
- Redirect to 32'h10 in the same cycle as ack and ins_ready with FIFO holding 2 entries -> nothing pushed or popped; ins_valid=0 next cycle; next request addr=8'h10.
- redirect_pc=32'h000000FF, zero-wait -> imem_addr FF then 00; ins_pc FF then 32'h00000100.
- Assert rstd=0 mid-REQ with 2 entries buffered -> immediately imem_req=0, ins_valid=0, ins=0. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_buf_if.sv
// Fetch-stage bus bundle: redirect from execute, imem req/ack, and the
// instruction valid/ready stream. master = fetch unit, slave = environment.
interface ifetch_buf_if #(
    parameter int AW = 8
);
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          ins_valid;
    logic [31:0]   ins;
    logic [31:0]   ins_pc;
    logic          ins_ready;

    modport master (
        input  redirect, redirect_pc, imem_ack, imem_rdata, ins_ready,
        output imem_req, imem_addr, ins_valid, ins, ins_pc
    );
    modport slave (
        output redirect, redirect_pc, imem_ack, imem_rdata, ins_ready,
        input  imem_req, imem_addr, ins_valid, ins, ins_pc
    );
endinterface

// File: rtl/ifetch_buf.sv
// Instruction prefetch buffer: sequential fetch with req/ack to imem,
// PC-tagged FIFO towards execute, flush and stale-response discard on redirect.
module ifetch_buf #(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rstd,
    ifetch_buf_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    state_t        state_q;
    logic [31:0]   fpc_q;
    logic          req_q;
    logic [AW-1:0] addr_q;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    entry_t        mem_q [DEPTH];

    logic ack, push, pop;

    always_comb begin
        ack     = req_q & bus.imem_ack;
        push    = ack & (state_q == REQ) & ~bus.redirect;
        pop     = (count_q != '0) & bus.ins_ready & ~bus.redirect;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_q  <= IDLE;
            fpc_q    <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC[AW-1:0];
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (bus.redirect) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            fpc_q    <= bus.redirect_pc;
            // an unacked request must still complete, so its answer is dropped in DISCARD
            case (state_q)
                REQ, DISCARD: begin
                    if (ack) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= DISCARD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end else begin
            count_q <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= '{pc: fpc_q, word: bus.imem_rdata};
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            case (state_q)
                IDLE: begin
                    if (count_q < CW'(DEPTH)) begin
                        req_q   <= 1'b1;
                        addr_q  <= fpc_q[AW-1:0];
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (ack) begin
                        fpc_q <= fpc_q + 32'd1;
                        // reserve a slot before issuing so no response can overflow
                        if (count_d < CW'(DEPTH)) begin
                            addr_q <= fpc_q[AW-1:0] + AW'(1);
                        end else begin
                            req_q   <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (ack) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.ins_valid = (count_q != '0);
    assign bus.ins       = mem_q[rd_ptr_q].word;
    assign bus.ins_pc    = mem_q[rd_ptr_q].pc;
endmodule

// File: tb/tb_ifetch_buf.sv
// Directed bench for ifetch_buf: streaming, backpressure, latency + discard,
// redirect collisions, address wrap and asynchronous reset.
module tb_ifetch_buf;
    logic clk = 1'b0;
    logic rstd;
    int   nchk = 0;
    int   nerr = 0;

    ifetch_buf_if #(.AW(8)) bus ();

    ifetch_buf #(.DEPTH(4), .AW(8), .RESET_PC(32'h0)) dut (
        .clk  (clk),
        .rstd (rstd),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Memory model: word = {C0FFEE, addr}; ack after lat wait cycles, or manual.
    logic mem_auto = 1'b1;
    logic man_ack  = 1'b0;
    logic auto_ack = 1'b0;
    int   lat      = 0;
    int   wcnt     = 0;

    assign bus.imem_ack   = mem_auto ? auto_ack : man_ack;
    assign bus.imem_rdata = {24'hC0FFEE, bus.imem_addr};

    always @(posedge clk) begin
        #2;
        if (bus.imem_req) begin
            if (wcnt >= lat) begin
                auto_ack = 1'b1;
                wcnt     = 0;
            end else begin
                auto_ack = 1'b0;
                wcnt     = wcnt + 1;
            end
        end else begin
            auto_ack = 1'b0;
            wcnt     = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] w(input logic [31:0] pc);
        return {24'hC0FFEE, pc[7:0]};
    endfunction

    task automatic do_reset();
        rstd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstd = 1'b1;
    endtask

    initial begin
        rstd            = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.ins_ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req",   {31'b0, bus.imem_req},  32'h0);
        chk("rst_addr",  {24'b0, bus.imem_addr}, 32'h0);
        chk("rst_valid", {31'b0, bus.ins_valid}, 32'h0);
        chk("rst_ins",   bus.ins,    32'h0);
        chk("rst_pc",    bus.ins_pc, 32'h0);

        // Stream, zero-wait, ready tied high
        bus.ins_ready = 1'b1;
        rstd = 1'b1;
        @(negedge clk);
        chk("s_req1",   {31'b0, bus.imem_req},  32'h1);
        chk("s_addr1",  {24'b0, bus.imem_addr}, 32'h0);
        chk("s_valid1", {31'b0, bus.ins_valid}, 32'h0);
        for (int k = 2; k < 7; k++) begin
            @(negedge clk);
            chk("s_addr",  {24'b0, bus.imem_addr}, 32'(k - 1));
            chk("s_valid", {31'b0, bus.ins_valid}, 32'h1);
            chk("s_pc",    bus.ins_pc, 32'(k - 2));
            chk("s_ins",   bus.ins,    w(32'(k - 2)));
        end

        // Backpressure: exactly DEPTH responses, then refetch at pc 4
        bus.ins_ready = 1'b0;
        do_reset();
        repeat (5) @(negedge clk);
        chk("bp_req_off", {31'b0, bus.imem_req},  32'h0);
        chk("bp_head",    bus.ins_pc, 32'h0);
        @(negedge clk);
        chk("bp_req_off2", {31'b0, bus.imem_req}, 32'h0);
        bus.ins_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop1", bus.ins_pc, 32'h1);
        chk("bp_req_idle", {31'b0, bus.imem_req}, 32'h0);
        @(negedge clk);
        chk("bp_pop2", bus.ins_pc, 32'h2);
        chk("bp_req_on", {31'b0, bus.imem_req},  32'h1);
        chk("bp_addr4",  {24'b0, bus.imem_addr}, 32'h4);
        @(negedge clk);
        chk("bp_pop3", bus.ins_pc, 32'h3);
        @(negedge clk);
        chk("bp_pc4",  bus.ins_pc, 32'h4);
        chk("bp_ins4", bus.ins,    w(32'h4));

        // Latency 3 with a redirect while pc 5 is outstanding
        lat = 0;
        do_reset();
        repeat (5) @(negedge clk);
        lat = 3;
        @(negedge clk);
        chk("lt_addr5", {24'b0, bus.imem_addr}, 32'h5);
        chk("lt_pc4",   bus.ins_pc, 32'h4);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        @(negedge clk);
        bus.redirect = 1'b0;
        chk("lt_disc_req",  {31'b0, bus.imem_req},  32'h1);
        chk("lt_disc_addr", {24'b0, bus.imem_addr}, 32'h5);
        chk("lt_flush",     {31'b0, bus.ins_valid}, 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("lt_novalid", {31'b0, bus.ins_valid}, 32'h0);
        end
        chk("lt_drop_req", {31'b0, bus.imem_req}, 32'h0);
        @(negedge clk);
        chk("lt_req40",  {31'b0, bus.imem_req},  32'h1);
        chk("lt_addr40", {24'b0, bus.imem_addr}, 32'h40);
        repeat (3) begin
            @(negedge clk);
            chk("lt_wait", {31'b0, bus.ins_valid}, 32'h0);
        end
        @(negedge clk);
        chk("lt_valid40", {31'b0, bus.ins_valid}, 32'h1);
        chk("lt_pc40",    bus.ins_pc, 32'h40);
        chk("lt_ins40",   bus.ins,    w(32'h40));

        // Redirect colliding with ack and pop, two entries buffered
        mem_auto      = 1'b0;
        man_ack       = 1'b1;
        bus.ins_ready = 1'b0;
        do_reset();
        repeat (3) @(negedge clk);
        chk("rc_valid", {31'b0, bus.ins_valid}, 32'h1);
        chk("rc_addr2", {24'b0, bus.imem_addr}, 32'h2);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h10;
        bus.ins_ready   = 1'b1;
        @(negedge clk);
        bus.redirect = 1'b0;
        chk("rc_flush", {31'b0, bus.ins_valid}, 32'h0);
        chk("rc_idle",  {31'b0, bus.imem_req},  32'h0);
        @(negedge clk);
        chk("rc_req",   {31'b0, bus.imem_req},  32'h1);
        chk("rc_addr",  {24'b0, bus.imem_addr}, 32'h10);
        chk("rc_nov",   {31'b0, bus.ins_valid}, 32'h0);
        @(negedge clk);
        chk("rc_pc10",  bus.ins_pc, 32'h10);

        // Address wrap at 0xFF
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFF;
        @(negedge clk);
        bus.redirect = 1'b0;
        @(negedge clk);
        chk("wr_addrFF", {24'b0, bus.imem_addr}, 32'hFF);
        @(negedge clk);
        chk("wr_addr00", {24'b0, bus.imem_addr}, 32'h00);
        chk("wr_pcFF",   bus.ins_pc, 32'hFF);
        chk("wr_insFF",  bus.ins,    w(32'hFF));
        @(negedge clk);
        chk("wr_pc100",  bus.ins_pc, 32'h100);
        chk("wr_ins100", bus.ins,    w(32'h100));

        // Asynchronous reset mid-REQ with two entries buffered
        bus.ins_ready = 1'b0;
        @(negedge clk);
        chk("ar_valid", {31'b0, bus.ins_valid}, 32'h1);
        chk("ar_head",  bus.ins_pc, 32'h100);
        #1 rstd = 1'b0;
        #1;
        chk("ar_req",   {31'b0, bus.imem_req},  32'h0);
        chk("ar_nov",   {31'b0, bus.ins_valid}, 32'h0);
        chk("ar_ins",   bus.ins,    32'h0);
        chk("ar_pc",    bus.ins_pc, 32'h0);
        chk("ar_addr",  {24'b0, bus.imem_addr}, 32'h0);
        @(negedge clk);
        rstd = 1'b1;
        @(negedge clk);
        chk("ar_req1",  {31'b0, bus.imem_req},  32'h1);
        chk("ar_addr0", {24'b0, bus.imem_addr}, 32'h0);
        @(negedge clk);
        chk("ar_pc0",   bus.ins_pc, 32'h0);
        chk("ar_ins0",  bus.ins,    w(32'h0));

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
